// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// mmio_uart_tx : memory-mapped UART transmitter (TX FIFO + 8N1 serialiser)
// Optional build macro UART_PARITY_EN: adds an even-parity bit (8E1 framing).
// Revision: 1.0
// ============================================================================
module mmio_uart_tx #(
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic [2:0]  mode,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]       C_REG_TXDATA = 2'd0;
  localparam logic [1:0]       C_REG_STATUS = 2'd1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------- decode
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_ovf_clr;
  logic w_full;
  logic w_empty;
  logic w_busy;

  assign sel        = (a[31:4] == BASE_ADDR[31:4]);
  assign w_push_req = we & sel & (a[3:2] == C_REG_TXDATA);
  assign w_ovf_clr  = we & sel & (a[3:2] == C_REG_STATUS) & wd[3];
  // A full FIFO refuses the byte even if the FSM pops on the same edge.
  assign w_push     = w_push_req & ~w_full;

  // mode, the byte offset and upper store data never affect behaviour.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, mode, a[1:0], wd[31:8]};

  // ------------------------------------------------------------------ FIFO
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  logic           r_ovf;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= wd[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ serialiser
  state_t         r_state;
  state_t         w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]     r_bit;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     r_shift;
  logic [7:0]     w_shift_nxt;
  logic           w_tx;
`ifdef UART_PARITY_EN
  logic           r_par;
  logic           w_par_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
`ifdef UART_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr[PTR_W-1:0]];
`ifdef UART_PARITY_EN
          w_par_nxt   = ^r_mem[r_rptr[PTR_W-1:0]];
`endif
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        w_tx = r_par;
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        w_tx = 1'b1;
        if (r_cnt == C_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign w_busy = (r_state != S_IDLE) | ~w_empty;
  assign busy   = w_busy;
  assign tx     = w_tx;

  always_comb begin
    rd = '0;
    if (sel && (a[3:2] == C_REG_STATUS)) begin
      rd = {28'b0, r_ovf, w_busy, w_empty, w_full};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// Testbench for mmio_uart_tx: register table, serial scoreboard, frame-timing
// and overflow/reset corner sequences (CLK_DIV=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

  localparam int          CLK_DIV    = 4;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_1000;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam logic [2:0] M_SB = 3'd0;
  localparam logic [2:0] M_SW = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] rd;
  logic        sel;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;

  mmio_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .mode  (mode),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] m);
    a    = addr;
    wd   = data;
    mode = m;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    a    = '0;
    wd   = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check(name, (n >= 2000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Serial receiver: samples mid-bit on falling clock edges and scores bytes.
  initial begin : monitor
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        check("rx_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          rx_byte[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        check("rx_parity", {31'b0, tx}, {31'b0, ^rx_byte});
`endif
        repeat (CLK_DIV) @(negedge clk);
        check("rx_stop", {31'b0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got byte 0x%0h, expected no frame", rx_byte);
        end else begin
          exp_byte = exp_q.pop_front();
          check("rx_byte", {24'b0, rx_byte}, {24'b0, exp_byte});
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  mode;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin : stim
    logic [FRAME_BITS-1:0] frame;
    logic [7:0] sb;
    int lows;
    int hi;
    int n;

    vecs[0]  = '{1'b0, 32'h0000_1000, 32'h0,        M_SB,  1'b1, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_1004, 32'h0,        M_SW,  1'b1, 32'h2};
    vecs[2]  = '{1'b0, 32'h0000_1008, 32'h0,        M_SW,  1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_100C, 32'h0,        M_SB,  1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_2000, 32'h0,        M_SW,  1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_1014, 32'h0,        M_SW,  1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_1008, 32'hFF,       M_SW,  1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_100C, 32'h5A,       M_SB,  1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_2000, 32'h55,       M_SB,  1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, M_SW, 1'b1, 32'h2};
    vecs[10] = '{1'b0, 32'h0000_1005, 32'h0,        M_LBU, 1'b1, 32'h2};
    vecs[11] = '{1'b0, 32'h8000_1004, 32'h0,        M_SW,  1'b0, 32'h0};

    rst = 1'b0; a = '0; wd = '0; we = 1'b0; mode = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    a = BASE_ADDR + 32'h4;
    #1;
    check("reset_status", rd, 32'h2);
    a = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Register map / write-qualification table
    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a; wd = vecs[i].wd; mode = vecs[i].mode; we = vecs[i].we;
      #1;
      check($sformatf("tbl%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
      tick();
      we = 1'b0;
      check($sformatf("tbl%0d_nopush", i), {31'b0, busy}, 32'd0);
    end
    a = '0; wd = '0;

    // Reset in DATA bit 3 of 0x35 (bit3 = 0)
    store(BASE_ADDR, 32'h35, M_SB);
    repeat (18) tick();
    check("pre_reset_tx", {31'b0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("midreset_tx", {31'b0, tx}, 32'd1);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    a = BASE_ADDR + 32'h4;
    #1;
    check("midreset_status", rd, 32'h2);
    a = '0;
    repeat (2) tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("post_reset_quiet", lows, 32'd0);
    mon_en = 1'b1;

    // Single byte 0xA5: cycle-exact frame and busy window
    sb = 8'hA5;
`ifdef UART_PARITY_EN
    frame = {1'b1, ^sb, sb, 1'b0};
`else
    frame = {1'b1, sb, 1'b0};
`endif
    exp_q.push_back(sb);
    store(BASE_ADDR, 32'hA5, M_SB);
    check("lat_tx_idle", {31'b0, tx}, 32'd1);
    check("lat_busy", {31'b0, busy}, 32'd1);
    lows = 0;
    for (int k = 0; k < FRAME_BITS * CLK_DIV; k++) begin
      tick();
      if (tx !== frame[k / CLK_DIV] || busy !== 1'b1) begin
        lows++;
        $display("FAIL frame_cycle%0d: got tx=%b busy=%b, expected tx=%b busy=1",
                 k, tx, busy, frame[k / CLK_DIV]);
      end
    end
    check("frame_cycles_bad", lows, 32'd0);
    tick();
    check("frame_end_tx", {31'b0, tx}, 32'd1);
    check("frame_end_busy", {31'b0, busy}, 32'd0);
    wait_idle("single_timeout");

    // Overflow: FSM holds 0x11, then 0x11..0x15 fill the depth-4 FIFO
    exp_q.push_back(8'h11);
    store(BASE_ADDR, 32'h11, M_SW);
    repeat (2) tick();
    for (int v = 8'h11; v <= 8'h15; v++) begin
      if (v <= 8'h14) exp_q.push_back(8'(v));
      store(BASE_ADDR, 32'(v), M_SW);
    end
    a = BASE_ADDR + 32'h4;
    #1;
    check("ovf_status", rd, 32'hD);
    store(BASE_ADDR + 32'h4, 32'h8, M_SW);
    a = BASE_ADDR + 32'h4;
    #1;
    check("ovf_cleared", rd, 32'h5);
    a = '0;
    wait_idle("ovf_timeout");

    // Word store sends only the low byte
    exp_q.push_back(8'h42);
    store(BASE_ADDR, 32'hDEAD_BE42, M_SW);
    a = BASE_ADDR + 32'h8;
    #1;
    check("rsvd_rd", rd, 32'h0);
    a = 32'h0000_2000;
    #1;
    check("far_sel", {31'b0, sel}, 32'd0);
    check("far_rd", rd, 32'h0);
    a = '0;
    wait_idle("word_timeout");

    // Back-to-back frames: exactly one idle-high clock between them
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    store(BASE_ADDR, 32'h00, M_SB);
    store(BASE_ADDR, 32'hFF, M_SB);
    a = BASE_ADDR + 32'h4;
    #1;
    check("b2b_status_queued", rd, 32'h4);
    n = 0;
    while (tx === 1'b0 && n < 200) begin tick(); n++; end
    hi = 0;
    while (tx === 1'b1 && hi < 200) begin tick(); hi++; end
    check("b2b_high_cycles", hi, CLK_DIV + 1);
    check("b2b_status_popped", rd, 32'h6);
    a = '0;
    wait_idle("b2b_timeout");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
